lsu: RTL and testbench
======================

# lsu

Load/store unit between the RV32 core datapath and the word-organised data memory. Accepts byte, half-word and word load/store requests at byte addresses and converts them into aligned whole-word memory accesses. Loads are lane-extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write; the memory's write port only ever sees whole-word writes. Misaligned or illegal requests are rejected without any memory access.

## Interface
- `RAM_SIZE_LOG`, default 8: log2 of memory depth in 32-bit words; address bits above `RAM_SIZE_LOG+1` are passed through and ignored by memory.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `mode` in 3: BYTE 000, HALF_WORD 001, WORD 010, U_BYTE 100, U_HALF_WORD 101.
- `addr` in 32: byte address.
- `wdata` in 32: store data, low bits used for sub-word stores.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse, registered.
- `misaligned` out 1: qualifies `done`; high = request rejected.
- `rdata` out 32: load result; holds until the next load completes.
- `m_ra` out 32: memory read address, word-aligned (`[1:0]`=0).
- `m_rm` out 3: memory read mode, constant WORD.
- `m_rd` in 32: memory read data, combinational from `m_ra`.
- `m_we` out 1: memory write enable.
- `m_wa` out 32: memory write address, word-aligned.
- `m_wm` out 3: memory write mode, constant WORD.
- `m_wd` out 32: memory write data.

## Operation
- States: IDLE, RD, WR.
- IDLE with `req`=1: latch `we`, `mode`, `addr` and `wdata`; `off = addr[1:0]`.
- Illegal request, checked in IDLE:
  - HALF/U_HALF with `off[0]`=1.
  - WORD with `off`≠0.
  - mode 011, 110 or 111.
  - store with U_BYTE or U_HALF_WORD.
  - Response: `done`=1, `misaligned`=1 next edge; stay IDLE; no memory access.
- Load: IDLE→RD.
  - In RD: `m_ra = {addr[31:2],2'b00}`.
  - At the RD edge: `rdata` ← lane extract of `m_rd`.
    - Byte lane `m_rd[8*off+:8]`; half lane `m_rd[16*off[1]+:16]`.
    - BYTE/HALF sign-extend; U_ variants zero-extend; WORD passes through.
  - Then `done`=1 and state→IDLE.
- Byte/half store: IDLE→RD.
  - At the RD edge: `wbuf` ← `m_rd` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Then state→WR.
- Word store: IDLE→WR with `wbuf` ← `wdata`.
- WR:
  - `m_we`=1 combinationally from state; `m_wa` = aligned addr; `m_wd` = `wbuf`.
  - Memory commits on the negedge inside the WR cycle.
  - Next edge: `done`=1, state→IDLE.
- `req` while busy is ignored and not queued.
- `m_we` is 0 in every state except WR.
- `m_ra` = aligned latched addr in all states.

## Timing
- Edge E0 = edge that accepts `req`.
- Latency, i.e. `done` high in the cycle after the listed edge:
  - illegal request: E0;
  - load: E1;
  - word store: E1;
  - sub-word store: E2.
- `busy` falls in the same cycle that `done` is high, so a new `req` can be accepted at the following edge. Throughput is one request per 2 cycles (load, word store) or 3 cycles (sub-word store).
- Reset values:
  - state IDLE;
  - `busy`, `done`, `misaligned`, `m_we` = 0;
  - `rdata`, `wbuf` and latched request = 0.
- Reset during RD: abort, no `done`, no write.
- Reset asserted in a WR cycle: that cycle's negedge write still occurs (reset is synchronous); state→IDLE at the edge; `done` suppressed.
- `misaligned` is meaningful only while `done`=1; it is cleared on every non-error `done`.

## Structure
- Shared package `mem_pkg`:
  - `RAM_SIZE_LOG`;
  - mode constants BYTE, HALF_WORD, WORD, U_BYTE, U_HALF_WORD;
  - `lsu_state_t` enum {IDLE, RD, WR}.
- Sub-module `lsu_lane` (combinational), shared by load extract and store merge:
  - extract: word, off, mode → extended value;
  - merge: word, off, mode, wdata → merged word.
- The top `lsu` holds the FSM and the request and `wbuf` registers.

## Test plan
- Memory word 0x10 = 0x8899AABB (little-endian lanes BB, AA, 99, 88):
  - BYTE load @0x11 → `rdata`=0xFFFFFFAA, `done` at E1, `m_we` never high;
  - U_BYTE @0x13 → 0x00000088;
  - HALF @0x12 → 0xFFFF8899.
- BYTE store 0x5A @0x12 → memory word 0x10 = 0x885AAABB; `m_we` high exactly one cycle (WR); `done` at E2.
- WORD store 0x12345678 @0x10 → no RD cycle; `m_we` in the cycle after E0; `done` at E1; memory = 0x12345678.
- Illegal requests → `done`+`misaligned` at E0, state stays IDLE, no `m_we`:
  - HALF load @0x11;
  - WORD store @0x12;
  - mode 011;
  - U_BYTE store.
- `req` held high continuously during a sub-word store → second request accepted only at the edge after `done`; back-to-back completions correct.
- `reset` pulsed in RD of a store → no `done`, no `m_we`, `busy`=0 next cycle, memory unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit and its lane helper.
package mem_pkg;

  localparam int RAM_SIZE_LOG = 8;

  localparam logic [2:0] BYTE        = 3'b000;
  localparam logic [2:0] HALF_WORD   = 3'b001;
  localparam logic [2:0] WORD        = 3'b010;
  localparam logic [2:0] U_BYTE      = 3'b100;
  localparam logic [2:0] U_HALF_WORD = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } lsu_state_t;

  // A request is illegal when its width does not fit its byte offset, when
  // the mode is unassigned, or when an unsigned mode is used for a store.
  function automatic logic is_illegal(input logic we, input logic [2:0] mode,
                                      input logic [1:0] off);
    case (mode)
      BYTE:        is_illegal = 1'b0;
      U_BYTE:      is_illegal = we;
      HALF_WORD:   is_illegal = off[0];
      U_HALF_WORD: is_illegal = we | off[0];
      WORD:        is_illegal = (off != 2'b00);
      default:     is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half-word lane logic shared by load extraction and store merging.
module lsu_lane
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  mode,
  input  logic [15:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, extend it, and build the merged store word.
  always_comb begin
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    ext    = word;
    merged = word;
    case (mode[1:0])
      2'b00: begin
        ext = {{24{byte_v[7] & ~mode[2]}}, byte_v};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        ext = {{16{half_v[15] & ~mode[2]}}, half_v};
        merged[{off[1], 4'b0000} +: 16] = wdata;
      end
      default: begin
        ext    = word;
        merged = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses,
// using read-modify-write for sub-word stores.
// Handshake: req is sampled only while busy=0; a completed request gives a
// single-cycle done pulse, qualified by misaligned, and busy is low in that
// same cycle so the next req is accepted at the following edge.
module lsu
  import mem_pkg::*;
#(
  parameter int RAM_SIZE_LOG = mem_pkg::RAM_SIZE_LOG
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] rdata,
  output logic [31:0] m_ra,
  output logic [2:0]  m_rm,
  input  logic [31:0] m_rd,
  output logic        m_we,
  output logic [31:0] m_wa,
  output logic [2:0]  m_wm,
  output logic [31:0] m_wd,
  output logic [1:0]  dbg_state
);

  lsu_state_t  state;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] wbuf;
  logic [31:0] lane_ext;
  logic [31:0] lane_merged;
  logic [31:0] aligned_addr;

  assign aligned_addr = {req_addr[31:2], 2'b00};

  lsu_lane u_lane (
    .word   (m_rd),
    .off    (req_addr[1:0]),
    .mode   (req_mode),
    .wdata  (req_wdata[15:0]),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  // Request capture, FSM sequencing, load result and store buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_mode   <= 3'b000;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      wbuf       <= 32'h0;
      rdata      <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            req_we    <= we;
            req_mode  <= mode;
            req_addr  <= addr;
            req_wdata <= wdata;
            if (is_illegal(we, mode, addr[1:0])) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (we && (mode == WORD)) begin
              wbuf  <= wdata;
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (req_we) begin
            wbuf  <= lane_merged;
            state <= WR;
          end else begin
            rdata      <= lane_ext;
            done       <= 1'b1;
            misaligned <= 1'b0;
            state      <= IDLE;
          end
        end
        WR: begin
          done       <= 1'b1;
          misaligned <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port drive: addresses always follow the latched request.
  always_comb begin
    busy      = (state != IDLE);
    m_we      = (state == WR);
    m_ra      = aligned_addr;
    m_wa      = aligned_addr;
    m_rm      = WORD;
    m_wm      = WORD;
    m_wd      = wbuf;
    dbg_state = state;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a word memory model and write/done monitors.
module tb_lsu;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] rdata;
  logic [31:0] m_ra;
  logic [2:0]  m_rm;
  logic [31:0] m_rd;
  logic        m_we;
  logic [31:0] m_wa;
  logic [2:0]  m_wm;
  logic [31:0] m_wd;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];
  int          we_cnt;
  int          done_cnt;
  int          compared;
  int          mismatched;
  int          lat;
  int          we_base;
  int          done_base;

  lsu #(.RAM_SIZE_LOG(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .mode       (mode),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .rdata      (rdata),
    .m_ra       (m_ra),
    .m_rm       (m_rm),
    .m_rd       (m_rd),
    .m_we       (m_we),
    .m_wa       (m_wa),
    .m_wm       (m_wm),
    .m_wd       (m_wd),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory: combinational read, negedge write.
  assign m_rd = mem[m_ra[9:2]];
  always @(negedge clk) begin
    if (m_we) mem[m_wa[9:2]] <= m_wd;
  end

  // Monitors for write strobes and completion pulses.
  initial begin
    we_cnt   = 0;
    done_cnt = 0;
  end
  always @(negedge clk) begin
    if (m_we) we_cnt = we_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (E0); returns #1 after E0.
  task automatic issue(input logic w, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] d);
    req   = 1'b1;
    we    = w;
    mode  = m;
    addr  = a;
    wdata = d;
    step();
    req = 1'b0;
  endtask

  // Count edges after E0 until done shows; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      step();
      n = n + 1;
    end
  endtask

  task automatic word_store(input logic [31:0] a, input logic [31:0] d, input string tag);
    issue(1'b1, WORD, a, d);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 1);
  endtask

  task automatic load_chk(input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] exp, input string tag);
    we_base = we_cnt;
    issue(1'b0, m, a, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    chk({tag, "_mra"}, m_ra, {a[31:2], 2'b00});
    wait_done(lat);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_mis"}, {31'b0, misaligned}, 0);
    chk({tag, "_busy_done"}, {31'b0, busy}, 0);
    chk({tag, "_nowe"}, we_cnt - we_base, 0);
  endtask

  task automatic illegal_chk(input logic w, input logic [2:0] m, input logic [31:0] a,
                             input string tag);
    we_base = we_cnt;
    issue(w, m, a, 32'hDEADBEEF);
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_mis"}, {31'b0, misaligned}, 1);
    chk({tag, "_state"}, {30'b0, dbg_state}, 0);
    step();
    chk({tag, "_done_clr"}, {31'b0, done}, 0);
    chk({tag, "_nowe"}, we_cnt - we_base, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    mode  = 3'b000;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mis", {31'b0, misaligned}, 0);
    chk("rst_mwe", {31'b0, m_we}, 0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mra", m_ra, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 0);
    chk("rst_modes", {26'b0, m_rm, m_wm}, {26'b0, 3'b010, 3'b010});

    // Word store: write in the cycle after E0, done at E1
    we_base = we_cnt;
    issue(1'b1, WORD, 32'h10, 32'h12345678);
    chk("wst_mwe", {31'b0, m_we}, 1);
    chk("wst_mwa", m_wa, 32'h10);
    chk("wst_mwd", m_wd, 32'h12345678);
    wait_done(lat);
    chk("wst_lat", lat, 1);
    chk("wst_mem", mem[4], 32'h12345678);
    chk("wst_we1", we_cnt - we_base, 1);

    // Preload through the DUT
    word_store(32'h10, 32'h8899AABB, "pre10");
    word_store(32'h14, 32'h11223344, "pre14");
    word_store(32'h20, 32'hAABBCCDD, "pre20");
    word_store(32'h24, 32'h01020304, "pre24");

    // Loads
    load_chk(BYTE,        32'h11, 32'hFFFFFFAA, "lb11");
    load_chk(U_BYTE,      32'h13, 32'h00000088, "lbu13");
    load_chk(HALF_WORD,   32'h12, 32'hFFFF8899, "lh12");
    load_chk(U_HALF_WORD, 32'h10, 32'h0000AABB, "lhu10");
    load_chk(BYTE,        32'h10, 32'hFFFFFFBB, "lb10");
    load_chk(WORD,        32'h10, 32'h8899AABB, "lw10");

    // Byte store via read-modify-write, done at E2, one write cycle
    we_base = we_cnt;
    issue(1'b1, BYTE, 32'h12, 32'hFFFFFF5A);
    chk("sb_rd_nowe", {31'b0, m_we}, 0);
    wait_done(lat);
    chk("sb_lat", lat, 2);
    chk("sb_mem", mem[4], 32'h885AAABB);
    chk("sb_we1", we_cnt - we_base, 1);
    chk("sb_rdata_hold", rdata, 32'h8899AABB);

    // Half store to upper half
    issue(1'b1, HALF_WORD, 32'h16, 32'h0000CAFE);
    wait_done(lat);
    chk("sh_lat", lat, 2);
    chk("sh_mem", mem[5], 32'hCAFE3344);

    // Illegal requests
    illegal_chk(1'b0, HALF_WORD, 32'h11, "ill_lh11");
    illegal_chk(1'b1, WORD,      32'h12, "ill_sw12");
    illegal_chk(1'b0, 3'b011,    32'h10, "ill_m011");
    illegal_chk(1'b1, U_BYTE,    32'h10, "ill_sbu");
    chk("ill_mem", mem[4], 32'h885AAABB);
    load_chk(WORD, 32'h14, 32'hCAFE3344, "lw14_misclr");

    // req held high across a sub-word store, then a load queued behind it
    req = 1'b1; we = 1'b1; mode = BYTE; addr = 32'h20; wdata = 32'h00000011;
    step();
    we = 1'b0; mode = WORD; addr = 32'h20; wdata = 32'h0;
    chk("b2b_e0_busy", {31'b0, busy}, 1);
    step();
    chk("b2b_e1_busy", {31'b0, busy}, 1);
    chk("b2b_e1_done", {31'b0, done}, 0);
    step();
    chk("b2b_e2_done", {31'b0, done}, 1);
    chk("b2b_e2_busy", {31'b0, busy}, 0);
    chk("b2b_mem", mem[8], 32'hAABBCC11);
    step();
    req = 1'b0;
    chk("b2b_e3_busy", {31'b0, busy}, 1);
    chk("b2b_e3_done", {31'b0, done}, 0);
    chk("b2b_e3_mra", m_ra, 32'h20);
    step();
    chk("b2b_e4_done", {31'b0, done}, 1);
    chk("b2b_e4_rdata", rdata, 32'hAABBCC11);

    // Reset while in RD of a byte store
    step();
    we_base   = we_cnt;
    done_base = done_cnt;
    issue(1'b1, BYTE, 32'h24, 32'h000000FF);
    chk("rrd_state", {30'b0, dbg_state}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rrd_busy", {31'b0, busy}, 0);
    chk("rrd_state_idle", {30'b0, dbg_state}, 0);
    repeat (3) step();
    chk("rrd_nodone", done_cnt - done_base, 0);
    chk("rrd_nowe", we_cnt - we_base, 0);
    chk("rrd_mem", mem[9], 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
